// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler sharing one spi_master between NREQ requesters: latches the winner's
// descriptor, starts the master, streams tx bytes through a 1-entry skid and routes rx bytes back.
module spi_xfer_sched #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned LENW   = 20,
    parameter int unsigned TO_CYC = 1048575
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] req_tx_len,
    input  logic [NREQ*LENW-1:0] req_rx_len,
    input  logic [NREQ-1:0]      req_seq,
    input  logic [NREQ-1:0]      req_tx_vld,
    input  logic [NREQ*8-1:0]    req_tx_byte,
    output logic [NREQ-1:0]      req_tx_rdy,
    output logic [NREQ-1:0]      req_rx_vld,
    output logic [7:0]           rx_byte,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic                 spi_start_pulse,
    output logic [LENW-1:0]      tx_len,
    output logic [LENW-1:0]      rx_len,
    output logic                 tx_rx_seq,
    output logic                 tx_buf_vld,
    output logic [7:0]           tx_buf_byte,
    input  logic                 tx_buf_req,
    output logic                 rx_buf_vld,
    input  logic                 rx_buf_req,
    input  logic [7:0]           rx_buf_byte,
    input  logic                 ncs
);

    localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WDW = (TO_CYC > 1) ? $clog2(TO_CYC + 1) : 1;
    localparam int unsigned UCW = 16;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_START, S_RUN, S_DONE} state_t;

    state_t          state, state_d;
    logic [PW-1:0]   ptr, ptr_d, own, own_d, win, arb_idx;
    logic            found;
    logic            ncs_q, ncs_rise;
    logic [LENW-1:0] tx_cnt, tx_cnt_d, tx_len_d, rx_len_d;
    logic [WDW-1:0]  wd_cnt, wd_cnt_d;
    logic [UCW-1:0]  underrun_cnt, underrun_cnt_d;
    logic [NREQ-1:0] gnt_d, done_d, req_tx_rdy_d, req_rx_vld_d, win_oh;
    logic            err_d, spi_start_pulse_d, tx_rx_seq_d, tx_buf_vld_d, rx_buf_vld_d;
    logic [7:0]      tx_buf_byte_d, rx_byte_d, own_byte;
    logic            own_vld, tx_load, tx_take, wd_hit, wd_sat;

    // Rotating priority search starting at ptr
    always_comb begin
        found   = 1'b0;
        win     = '0;
        arb_idx = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            arb_idx = PW'((int'(ptr) + i) % int'(NREQ));
            if (!found && req[arb_idx]) begin
                found = 1'b1;
                win   = arb_idx;
            end
        end
    end

    assign win_oh   = NREQ'(1) << win;
    assign own_vld  = req_tx_vld[own];
    assign own_byte = req_tx_byte[int'(own)*8 +: 8];
    assign ncs_rise = ncs & ~ncs_q;
    assign wd_sat   = (wd_cnt == WDW'(TO_CYC));
    assign wd_hit   = (TO_CYC != 0) && wd_sat;
    assign tx_take  = tx_buf_req & tx_buf_vld;
    // The rdy cycle is skipped so the requester can advance its byte before the next load
    assign tx_load  = (state == S_RUN) && (!tx_buf_vld || tx_buf_req) && own_vld
                      && (req_tx_rdy == '0) && (tx_cnt != tx_len);

    always_comb begin
        state_d           = state;
        ptr_d             = ptr;
        own_d             = own;
        tx_cnt_d          = tx_cnt;
        tx_len_d          = tx_len;
        rx_len_d          = rx_len;
        tx_rx_seq_d       = tx_rx_seq;
        wd_cnt_d          = wd_cnt;
        underrun_cnt_d    = underrun_cnt;
        gnt_d             = gnt;
        done_d            = '0;
        err_d             = 1'b0;
        spi_start_pulse_d = 1'b0;
        req_tx_rdy_d      = '0;
        req_rx_vld_d      = '0;
        rx_byte_d         = rx_byte;
        tx_buf_vld_d      = tx_buf_vld;
        tx_buf_byte_d     = tx_buf_byte;
        rx_buf_vld_d      = 1'b0;

        case (state)
            S_IDLE: begin
                if ((req != '0) && ncs) state_d = S_ARB;
            end
            S_ARB: begin
                state_d        = S_IDLE;
                wd_cnt_d       = '0;
                underrun_cnt_d = '0;
                tx_cnt_d       = '0;
                if (found) begin
                    ptr_d       = PW'((int'(win) + 1) % int'(NREQ));
                    own_d       = win;
                    tx_len_d    = req_tx_len[int'(win)*int'(LENW) +: LENW];
                    rx_len_d    = req_rx_len[int'(win)*int'(LENW) +: LENW];
                    tx_rx_seq_d = req_seq[win];
                    if ((req_tx_len[int'(win)*int'(LENW) +: LENW] == '0) &&
                        (req_rx_len[int'(win)*int'(LENW) +: LENW] == '0)) begin
                        done_d = win_oh;
                    end else begin
                        gnt_d             = win_oh;
                        spi_start_pulse_d = 1'b1;
                        state_d           = S_START;
                    end
                end
            end
            S_START: begin
                state_d      = S_RUN;
                rx_buf_vld_d = 1'b1;
                if (!wd_sat) wd_cnt_d = wd_cnt + WDW'(1);
            end
            S_RUN: begin
                rx_buf_vld_d = 1'b1;
                if (!wd_sat) wd_cnt_d = wd_cnt + WDW'(1);
                if (tx_take) begin
                    tx_buf_vld_d  = 1'b0;
                    tx_buf_byte_d = '0;
                end
                if (tx_buf_req && !tx_buf_vld && (underrun_cnt != '1))
                    underrun_cnt_d = underrun_cnt + UCW'(1);
                if (tx_load) begin
                    tx_buf_vld_d  = 1'b1;
                    tx_buf_byte_d = own_byte;
                    req_tx_rdy_d  = gnt;
                    tx_cnt_d      = tx_cnt + LENW'(1);
                end
                if (rx_buf_req) begin
                    rx_byte_d    = rx_buf_byte;
                    req_rx_vld_d = gnt;
                end
                // A real ncs rise wins over a simultaneous watchdog expiry
                if (ncs_rise || wd_hit) begin
                    state_d       = S_DONE;
                    done_d        = gnt;
                    err_d         = ~ncs_rise;
                    tx_buf_vld_d  = 1'b0;
                    tx_buf_byte_d = '0;
                    rx_buf_vld_d  = 1'b0;
                    req_tx_rdy_d  = '0;
                    tx_cnt_d      = tx_cnt;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state           <= S_IDLE;
            ptr             <= '0;
            own             <= '0;
            ncs_q           <= 1'b1;
            tx_cnt          <= '0;
            wd_cnt          <= '0;
            underrun_cnt    <= '0;
            tx_len          <= '0;
            rx_len          <= '0;
            tx_rx_seq       <= 1'b0;
            gnt             <= '0;
            done            <= '0;
            err             <= 1'b0;
            spi_start_pulse <= 1'b0;
            req_tx_rdy      <= '0;
            req_rx_vld      <= '0;
            rx_byte         <= '0;
            tx_buf_vld      <= 1'b0;
            tx_buf_byte     <= '0;
            rx_buf_vld      <= 1'b0;
        end else begin
            state           <= state_d;
            ptr             <= ptr_d;
            own             <= own_d;
            ncs_q           <= ncs;
            tx_cnt          <= tx_cnt_d;
            wd_cnt          <= wd_cnt_d;
            underrun_cnt    <= underrun_cnt_d;
            tx_len          <= tx_len_d;
            rx_len          <= rx_len_d;
            tx_rx_seq       <= tx_rx_seq_d;
            gnt             <= gnt_d;
            done            <= done_d;
            err             <= err_d;
            spi_start_pulse <= spi_start_pulse_d;
            req_tx_rdy      <= req_tx_rdy_d;
            req_rx_vld      <= req_rx_vld_d;
            rx_byte         <= rx_byte_d;
            tx_buf_vld      <= tx_buf_vld_d;
            tx_buf_byte     <= tx_buf_byte_d;
            rx_buf_vld      <= rx_buf_vld_d;
        end
    end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed scoreboard bench for spi_xfer_sched: bench-side requester and spi_master models.
module tb_spi_xfer_sched;

    localparam int unsigned NREQ   = 2;
    localparam int unsigned LENW   = 20;
    localparam int unsigned TO_CYC = 300;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req;
    logic [NREQ*LENW-1:0] req_tx_len, req_rx_len;
    logic [NREQ-1:0]      req_seq, req_tx_vld;
    logic [NREQ*8-1:0]    req_tx_byte;
    logic [NREQ-1:0]      req_tx_rdy, req_rx_vld, gnt, done;
    logic [7:0]           rx_byte, tx_buf_byte, rx_buf_byte;
    logic                 err, spi_start_pulse, tx_rx_seq, tx_buf_vld, tx_buf_req;
    logic                 rx_buf_vld, rx_buf_req, ncs;
    logic [LENW-1:0]      tx_len, rx_len;

    always #5 clk = ~clk;

    spi_xfer_sched #(.NREQ(NREQ), .LENW(LENW), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_tx_len(req_tx_len), .req_rx_len(req_rx_len),
        .req_seq(req_seq), .req_tx_vld(req_tx_vld), .req_tx_byte(req_tx_byte),
        .req_tx_rdy(req_tx_rdy), .req_rx_vld(req_rx_vld), .rx_byte(rx_byte), .gnt(gnt),
        .done(done), .err(err), .spi_start_pulse(spi_start_pulse), .tx_len(tx_len),
        .rx_len(rx_len), .tx_rx_seq(tx_rx_seq), .tx_buf_vld(tx_buf_vld),
        .tx_buf_byte(tx_buf_byte), .tx_buf_req(tx_buf_req), .rx_buf_vld(rx_buf_vld),
        .rx_buf_req(rx_buf_req), .rx_buf_byte(rx_buf_byte), .ncs(ncs)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_tx[$], sb_rx[$], src0[$], src1[$];
    logic [2:0] exp_done[$];   // {done one-hot, err}
    int n_start = 0, n_done = 0, n_rx = 0, exp_und = 0, stall_n = 0;
    int n_rdy [2];
    int stall [2];
    logic [7:0] last_tx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Requester i: presents the head of its source queue, stalls stall_n cycles after each accept
    task automatic req_model(input int i);
        if (req_tx_rdy[i]) begin
            sb_tx.push_back(req_tx_byte[i*8 +: 8]);
            n_rdy[i]++;
            if (i == 0 && src0.size() > 0) void'(src0.pop_front());
            if (i == 1 && src1.size() > 0) void'(src1.pop_front());
            req_tx_vld[i] = 1'b0;
            stall[i] = stall_n;
        end else if (!req_tx_vld[i] && stall[i] > 0) begin
            stall[i]--;
        end
        if (!req_tx_vld[i] && stall[i] == 0) begin
            if (i == 0 && src0.size() > 0) begin
                req_tx_byte[7:0] = src0[0];
                req_tx_vld[0] = 1'b1;
            end
            if (i == 1 && src1.size() > 0) begin
                req_tx_byte[15:8] = src1[0];
                req_tx_vld[1] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        logic [2:0] e;
        @(posedge clk);
        #1;
        if (spi_start_pulse) n_start++;
        if (done != '0 || err) begin
            n_done++;
            if (exp_done.size() == 0) chk("done_unexpected", {29'd0, done, err}, 0);
            else begin
                e = exp_done.pop_front();
                chk("done_owner_err", {29'd0, done, err}, {29'd0, e});
            end
        end
        if (req_rx_vld != '0) begin
            n_rx++;
            if (sb_rx.size() == 0) chk("rx_unexpected", {30'd0, req_rx_vld}, 0);
            else begin
                chk("rx_byte", {24'd0, rx_byte}, {24'd0, sb_rx.pop_front()});
                chk("rx_owner", {30'd0, req_rx_vld}, {30'd0, gnt});
            end
        end
        if (req_tx_rdy != '0) chk("rdy_owner", {30'd0, req_tx_rdy & ~gnt}, 0);
        req_model(0);
        req_model(1);
    endtask

    task automatic set_desc(input int i, input int txl, input int rxl, input logic seq);
        req_tx_len[i*LENW +: LENW] = LENW'(txl);
        req_rx_len[i*LENW +: LENW] = LENW'(rxl);
        req_seq[i] = seq;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {23'd0, gnt, done, err, spi_start_pulse, tx_rx_seq, tx_buf_vld,
                             rx_buf_vld}, 0);
        chk({tag, "_pulses"}, {28'd0, req_tx_rdy, req_rx_vld}, 0);
        chk({tag, "_lens"}, {12'd0, tx_len}, {12'd0, rx_len});
        chk({tag, "_txlen"}, {12'd0, tx_len}, 0);
        chk({tag, "_bytes"}, {16'd0, rx_byte, tx_buf_byte}, 0);
    endtask

    // spi_master model: waits for start, drains ntx tx bytes, returns nrx rx bytes, raises ncs
    task automatic serve(input int ntx, input int nrx, input logic [1:0] exp_gnt,
                         input bit drop, input int gap, input bit loop);
        int k;
        int got;
        logic [7:0] b;
        k = 0;
        while (spi_start_pulse !== 1'b1 && k < 20) begin tick(); k++; end
        chk("start_seen", {31'd0, spi_start_pulse}, 1);
        chk("gnt_owner", {30'd0, gnt}, {30'd0, exp_gnt});
        chk("tx_len_out", {12'd0, tx_len}, ntx);
        chk("rx_len_out", {12'd0, rx_len}, nrx);
        if (drop) req = '0;
        tick();
        ncs = 1'b0;
        got = 0;
        k = 0;
        while (got < ntx && k < 400) begin
            repeat (gap) tick();
            chk("rx_buf_vld_run", {31'd0, rx_buf_vld}, 1);
            tx_buf_req = 1'b1;
            if (tx_buf_vld) begin
                if (sb_tx.size() > 0) chk("tx_byte", {24'd0, tx_buf_byte}, {24'd0, sb_tx.pop_front()});
                else chk("tx_unexpected", {31'd0, tx_buf_vld}, 0);
                last_tx = tx_buf_byte;
                got++;
            end else begin
                exp_und++;
                chk("underrun_byte", {24'd0, tx_buf_byte}, 0);
            end
            tick();
            tx_buf_req = 1'b0;
            k++;
        end
        chk("tx_consumed", got, ntx);
        for (int j = 0; j < nrx; j++) begin
            b = loop ? last_tx : 8'($urandom);
            rx_buf_req  = 1'b1;
            rx_buf_byte = b;
            sb_rx.push_back(b);
            k = n_rx;
            tick();
            rx_buf_req = 1'b0;
            chk("rx_latency", n_rx, k + 1);
            tick();
        end
        repeat (2) tick();
        ncs = 1'b1;
        got = n_done;
        k = 0;
        while (n_done == got && k < 20) begin tick(); k++; end
        chk("done_seen", n_done - got, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int d0;
        int ns0;
        rstn = 1'b0; req = '0; req_tx_len = '0; req_rx_len = '0; req_seq = '0;
        req_tx_vld = '0; req_tx_byte = '0; tx_buf_req = 1'b0; rx_buf_req = 1'b0;
        rx_buf_byte = '0; ncs = 1'b1;
        n_rdy[0] = 0; n_rdy[1] = 0; stall[0] = 0; stall[1] = 0;
        repeat (3) tick();
        chk_zero("reset");
        rstn = 1'b1;
        tick();

        // Round robin with both requests held for four transactions
        set_desc(0, 1, 0, 1'b0);
        set_desc(1, 2, 0, 1'b1);
        src0.push_back(8'h01); src0.push_back(8'h02);
        for (int j = 0; j < 4; j++) src1.push_back(8'(8'h80 + j));
        exp_done.push_back(3'b010); exp_done.push_back(3'b100);
        exp_done.push_back(3'b010); exp_done.push_back(3'b100);
        req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            if (t % 2 == 0) serve(1, 0, 2'b01, t == 3, 1, 1'b0);
            else            serve(2, 0, 2'b10, t == 3, 1, 1'b0);
        end
        repeat (3) tick();

        // Single tx byte: start two cycles after req, one accept
        set_desc(0, 1, 0, 1'b0);
        src0.push_back(8'hA5);
        n_rdy[0] = 0;
        exp_done.push_back(3'b010);
        req = 2'b01;
        tick();
        chk("t1_no_early_start", {31'd0, spi_start_pulse}, 0);
        tick();
        chk("t1_start_latency", {31'd0, spi_start_pulse}, 1);
        serve(1, 0, 2'b01, 1'b1, 1, 1'b0);
        chk("t1_rdy_count", n_rdy[0], 1);
        repeat (2) tick();

        // Loopback: the received byte equals the transmitted one
        set_desc(0, 1, 1, 1'b1);
        src0.push_back(8'h5A);
        exp_done.push_back(3'b010);
        req = 2'b01;
        serve(1, 1, 2'b01, 1'b1, 1, 1'b1);
        chk("t2_seq", {31'd0, tx_rx_seq}, 1);
        chk("t2_rx_byte", {24'd0, rx_byte}, 32'h5A);
        repeat (2) tick();

        // 19 bytes with a stalling requester: exact accept count, no extra load
        set_desc(0, 19, 0, 1'b0);
        for (int j = 0; j < 21; j++) src0.push_back(8'(8'h10 + j));
        stall_n = 3;
        n_rdy[0] = 0;
        exp_und = 0;
        exp_done.push_back(3'b010);
        req = 2'b01;
        serve(19, 0, 2'b01, 1'b1, 1, 1'b0);
        chk("t4_rdy_count", n_rdy[0], 19);
        chk("t4_leftover", src0.size(), 2);
        chk("t4_underruns", {16'd0, dut.underrun_cnt}, exp_und);
        chk("t4_had_underrun", {31'd0, exp_und > 0}, 1);
        chk("t4_buf_empty", {31'd0, tx_buf_vld}, 0);
        src0.delete();
        stall_n = 0; stall[0] = 0; req_tx_vld[0] = 1'b0;
        repeat (2) tick();

        // Zero-length descriptor completes without starting the master
        set_desc(0, 0, 0, 1'b0);
        exp_done.push_back(3'b010);
        ns0 = n_start;
        req = 2'b01;
        tick();
        chk("t5_no_start_arb", {31'd0, spi_start_pulse}, 0);
        tick();
        chk("t5_done", {30'd0, done}, 32'h1);
        chk("t5_no_start", {31'd0, spi_start_pulse}, 0);
        req = '0;
        repeat (4) tick();
        chk("t5_start_count", n_start, ns0);

        // Watchdog abort with ncs held low
        set_desc(0, 1, 0, 1'b0);
        exp_done.push_back(3'b011);
        req = 2'b01;
        c = 0;
        while (spi_start_pulse !== 1'b1 && c < 20) begin tick(); c++; end
        chk("wd_start", {31'd0, spi_start_pulse}, 1);
        req = '0;
        tick();
        ncs = 1'b0;
        c = 1;
        d0 = n_done;
        while (n_done == d0 && c < int'(TO_CYC) + 20) begin tick(); c++; end
        chk("wd_window", {31'd0, (c >= int'(TO_CYC)) && (c <= int'(TO_CYC) + 2)}, 1);
        ncs = 1'b1;
        repeat (3) tick();

        // Reset mid-RUN: everything clears, no done, next request served normally
        set_desc(0, 2, 0, 1'b0);
        src0.push_back(8'h11); src0.push_back(8'h22);
        req = 2'b01;
        c = 0;
        while (spi_start_pulse !== 1'b1 && c < 20) begin tick(); c++; end
        req = '0;
        tick();
        ncs = 1'b0;
        repeat (4) tick();
        chk("t6_in_run", {30'd0, gnt}, 32'h1);
        rstn = 1'b0;
        tick();
        chk_zero("t6_reset");
        rstn = 1'b1;
        ncs = 1'b1;
        sb_tx.delete(); src0.delete(); req_tx_vld = '0;
        d0 = n_done;
        repeat (6) tick();
        chk("t6_no_done", n_done, d0);
        set_desc(0, 1, 0, 1'b0);
        src0.push_back(8'h3C);
        exp_done.push_back(3'b010);
        req = 2'b01;
        serve(1, 0, 2'b01, 1'b1, 1, 1'b0);
        repeat (3) tick();

        chk("sb_tx_empty", sb_tx.size(), 0);
        chk("sb_rx_empty", sb_rx.size(), 0);
        chk("exp_done_empty", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
